// File: rtl/pwm_ramp_scheduler_pkg.sv
// Shared types, channel ids and default limits for the PWM ramp scheduler.
package pwm_sched_pkg;

  localparam int DUTY_W = 19;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2
  } esc_state_t;

  localparam logic [1:0] CH_SERVO0 = 2'd0;
  localparam logic [1:0] CH_ESC    = 2'd1;
  localparam logic [1:0] CH_SERVO2 = 2'd2;

  localparam logic [DUTY_W-1:0] DEF_SERVO_MIN    = 19'd12000;
  localparam logic [DUTY_W-1:0] DEF_SERVO_MAX    = 19'd24000;
  localparam logic [DUTY_W-1:0] DEF_SERVO_CENTER = 19'd18000;
  localparam logic [DUTY_W-1:0] DEF_ESC_MIN      = 19'd12000;
  localparam logic [DUTY_W-1:0] DEF_ESC_MAX      = 19'd22800;
  localparam logic [DUTY_W-1:0] DEF_SERVO_STEP   = 19'd600;
  localparam logic [DUTY_W-1:0] DEF_ESC_STEP     = 19'd240;
  localparam int                DEF_ARM_FRAMES   = 500;

  // Saturate a requested duty into the safe pulse-width window.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                   input logic [DUTY_W-1:0] lo,
                                                   input logic [DUTY_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pwm_ramp_scheduler_if.sv
// Command channel between a host and the ramp scheduler (valid/ready plus error pulse).
interface pwm_ramp_scheduler_if;
  import pwm_sched_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_ch;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_err;

  modport master (output cmd_valid, output cmd_ch, output cmd_duty,
                  input  cmd_ready, input  cmd_err);
  modport slave  (input  cmd_valid, input  cmd_ch, input  cmd_duty,
                  output cmd_ready, output cmd_err);
endinterface

// File: rtl/pwm_ramp_channel.sv
// One PWM channel: clamped target register and a frame-gated slew limiter on duty.
module pwm_ramp_channel
  import pwm_sched_pkg::*;
#(
  parameter logic [DUTY_W-1:0] MIN        = DEF_SERVO_MIN,
  parameter logic [DUTY_W-1:0] MAX        = DEF_SERVO_MAX,
  parameter logic [DUTY_W-1:0] STEP       = DEF_SERVO_STEP,
  parameter logic [DUTY_W-1:0] RST_DUTY   = DEF_SERVO_CENTER,
  parameter logic [DUTY_W-1:0] RST_TARGET = DEF_SERVO_CENTER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_val,
  input  logic              frame,
  input  logic              enable,
  input  logic              force_en,
  input  logic [DUTY_W-1:0] force_val,
  output logic [DUTY_W-1:0] duty,
  output logic              clamped
);

  localparam logic signed [DUTY_W:0] STEP_S = $signed({1'b0, STEP});
  localparam logic signed [DUTY_W:0] NSTEP_S = -STEP_S;

  logic [DUTY_W-1:0]        target;
  logic signed [DUTY_W:0]   diff;
  logic [DUTY_W-1:0]        step_val;

  // Next duty if this frame ramps: jump to target when close, else one step toward it.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, duty});
    clamped  = (load_val < MIN) || (load_val > MAX);
    step_val = target;
    if (diff > STEP_S)
      step_val = duty + STEP;
    else if (diff < NSTEP_S)
      step_val = duty - STEP;
  end

  // Target takes clamped loads; duty follows forced values or ramps only on a frame strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target <= RST_TARGET;
      duty   <= RST_DUTY;
    end else begin
      if (load)
        target <= clamp_duty(load_val, MIN, MAX);
      if (force_en)
        duty <= force_val;
      else if (frame && enable)
        duty <= step_val;
    end
  end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Duty-register owner for the 3-channel PWM generator: command handshake, ESC arming FSM.
module pwm_ramp_scheduler
  import pwm_sched_pkg::*;
#(
  parameter logic [DUTY_W-1:0] SERVO_MIN    = DEF_SERVO_MIN,
  parameter logic [DUTY_W-1:0] SERVO_MAX    = DEF_SERVO_MAX,
  parameter logic [DUTY_W-1:0] SERVO_CENTER = DEF_SERVO_CENTER,
  parameter logic [DUTY_W-1:0] ESC_MIN      = DEF_ESC_MIN,
  parameter logic [DUTY_W-1:0] ESC_MAX      = DEF_ESC_MAX,
  parameter logic [DUTY_W-1:0] SERVO_STEP   = DEF_SERVO_STEP,
  parameter logic [DUTY_W-1:0] ESC_STEP     = DEF_ESC_STEP,
  parameter int                ARM_FRAMES   = DEF_ARM_FRAMES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pwm_ramp_scheduler_if.slave    cmd,
  input  logic                   arm_req,
  input  logic                   disarm,
  input  logic                   frame0,
  input  logic                   frame1,
  input  logic                   frame2,
  output logic [DUTY_W-1:0]      duty0,
  output logic [DUTY_W-1:0]      duty1,
  output logic [DUTY_W-1:0]      duty2,
  output logic                   esc_armed
);

  localparam int CNT_W = $clog2(ARM_FRAMES + 1);

  esc_state_t        state, state_next;
  logic [CNT_W-1:0]  arm_cnt, arm_cnt_next;
  logic              ready_q, err_q, err_next;
  logic              accept, ch1_cmd_ok, arm_load;
  logic              load0, load1, load2;
  logic [DUTY_W-1:0] load1_val;
  logic              force1;
  logic [DUTY_W-1:0] force1_val;
  logic              clamped0, clamped1, clamped2;

  assign cmd.cmd_ready = ready_q;
  assign cmd.cmd_err   = err_q;
  assign esc_armed     = (state == ARMED);
  assign accept        = cmd.cmd_valid && ready_q;

  // ESC arming sequence; disarm wins over everything and zeroes duty1 immediately.
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    force1       = 1'b0;
    force1_val   = '0;
    arm_load     = 1'b0;
    case (state)
      DISARMED: begin
        if (arm_req) begin
          state_next   = ARMING;
          arm_cnt_next = '0;
          force1       = 1'b1;
          force1_val   = ESC_MIN;
          arm_load     = 1'b1;
        end
      end
      ARMING: begin
        if (!arm_req) begin
          state_next = DISARMED;
          force1     = 1'b1;
        end else if (frame1) begin
          arm_cnt_next = arm_cnt + CNT_W'(1);
          if ((arm_cnt + CNT_W'(1)) == CNT_W'(ARM_FRAMES))
            state_next = ARMED;
        end
      end
      ARMED: ;
      default: state_next = DISARMED;
    endcase
    if (disarm) begin
      state_next = DISARMED;
      force1     = 1'b1;
      force1_val = '0;
      arm_load   = 1'b0;
    end
  end

  // Command decode: route loads per channel and flag ignored or clamped commands.
  always_comb begin
    ch1_cmd_ok = accept && (cmd.cmd_ch == CH_ESC) && (state == ARMED) && !disarm;
    load0      = accept && (cmd.cmd_ch == CH_SERVO0);
    load2      = accept && (cmd.cmd_ch == CH_SERVO2);
    load1      = ch1_cmd_ok || arm_load;
    load1_val  = arm_load ? ESC_MIN : cmd.cmd_duty;
    err_next   = 1'b0;
    if (accept) begin
      case (cmd.cmd_ch)
        CH_SERVO0: err_next = clamped0;
        CH_ESC:    err_next = !ch1_cmd_ok || clamped1;
        CH_SERVO2: err_next = clamped2;
        default:   err_next = 1'b1;
      endcase
    end
  end

  // FSM state and arming frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= DISARMED;
      arm_cnt <= '0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
    end
  end

  // Ready comes up one cycle after reset; error is a one-cycle registered pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_next;
    end
  end

  pwm_ramp_channel #(
    .MIN(SERVO_MIN), .MAX(SERVO_MAX), .STEP(SERVO_STEP),
    .RST_DUTY(SERVO_CENTER), .RST_TARGET(SERVO_CENTER)
  ) u_ch0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .load_val(cmd.cmd_duty),
    .frame(frame0), .enable(1'b1), .force_en(1'b0), .force_val('0),
    .duty(duty0), .clamped(clamped0)
  );

  pwm_ramp_channel #(
    .MIN(ESC_MIN), .MAX(ESC_MAX), .STEP(ESC_STEP),
    .RST_DUTY('0), .RST_TARGET(ESC_MIN)
  ) u_ch1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .load_val(load1_val),
    .frame(frame1), .enable(state == ARMED), .force_en(force1), .force_val(force1_val),
    .duty(duty1), .clamped(clamped1)
  );

  pwm_ramp_channel #(
    .MIN(SERVO_MIN), .MAX(SERVO_MAX), .STEP(SERVO_STEP),
    .RST_DUTY(SERVO_CENTER), .RST_TARGET(SERVO_CENTER)
  ) u_ch2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .load_val(cmd.cmd_duty),
    .frame(frame2), .enable(1'b1), .force_en(1'b0), .force_val('0),
    .duty(duty2), .clamped(clamped2)
  );

endmodule

// File: doc/pwm_ramp_scheduler.md
Name: pwm_ramp_scheduler

Overview:
- Sits upstream of the 3-channel PWM generator (servo0 at 50 Hz, ESC1 at 500 Hz, servo2 at 50 Hz).
- Owns the duty-cycle registers, in clock counts, that the generator compares against.
- Accepts target commands over a valid/ready interface, clamps them to safe pulse widths, and slew-limits them once per PWM frame.
- Sequences the ESC arming procedure: hold minimum throttle for a fixed number of frames before throttle commands are honoured.

Parameters:
- DUTY_W, 19, width of duty and target values (clock counts)
- SERVO_MIN, 12000, 1.0 ms at 12 MHz; lower clamp for ch0/ch2
- SERVO_MAX, 24000, 2.0 ms; upper clamp for ch0/ch2
- SERVO_CENTER, 18000, reset duty/target for ch0/ch2
- ESC_MIN, 12000, ESC idle throttle; arming level; lower clamp for ch1
- ESC_MAX, 22800, upper clamp for ch1 (95% of the 24000-count frame)
- SERVO_STEP, 600, max duty change per frame for ch0/ch2
- ESC_STEP, 240, max duty change per frame for ch1
- ARM_FRAMES, 500, ch1 frames held at ESC_MIN before ARMED (1 s)

Ports:
- clk  in  1  12 MHz system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted
- cmd_ch  in  2  target channel 0..2; 3 is illegal
- cmd_duty  in  DUTY_W  requested duty in clock counts
- cmd_err  out  1  one-cycle pulse: command clamped or rejected
- arm_req  in  1  level; request ESC arming
- disarm  in  1  level; force ESC off
- frame0, frame1, frame2  in  1 each  one-cycle strobe when the generator's channel counter wraps to 0
- duty0, duty1, duty2  out  DUTY_W each  duty registers fed to the generator
- esc_armed  out  1  high in ARMED state

Behaviour:
- Reset values (registered, rst_n low at clk edge):
  - duty0 = duty2 = SERVO_CENTER; targets 0 and 2 = SERVO_CENTER.
  - duty1 = 0; target1 = ESC_MIN.
  - cmd_ready = 0; cmd_err = 0; esc_armed = 0; state = DISARMED; arm_cnt = 0.
  - cmd_ready goes to 1 on the first cycle after reset is released and stays 1.
- Handshake:
  - Command is accepted on a cycle where cmd_valid && cmd_ready.
  - Target register is written at that edge.
  - cmd_err pulses on the following cycle when any of these hold:
    - cmd_ch == 3: command ignored.
    - ch1 while state != ARMED: command ignored.
    - Value was clamped to [MIN, MAX]: clamped value is stored.
- Ramp, per channel k, evaluated only on the cycle frame_k = 1:
  - diff = target_k - duty_k.
  - If |diff| <= STEP, duty_k <= target_k.
  - Otherwise duty_k moves STEP toward target_k.
  - New duty is visible the cycle after the strobe. Duty never changes between strobes, except the ch1 disarm path below.
  - Arithmetic is DUTY_W+1 signed; no wrap is possible because targets are clamped.
- Simultaneous command and frame_k on the same cycle: the ramp uses the old target; the new target applies from the next frame.
- ESC FSM (ch1):
  - DISARMED: duty1 held 0. arm_req && !disarm -> ARMING; duty1 <= ESC_MIN and target1 <= ESC_MIN immediately, not frame-gated; arm_cnt <= 0.
  - ARMING: duty1 held at ESC_MIN; each frame1 increments arm_cnt. The frame1 that makes arm_cnt == ARM_FRAMES -> ARMED. Dropping arm_req aborts to DISARMED with duty1 <= 0.
  - ARMED: esc_armed = 1; ramping and ch1 commands enabled. arm_req is ignored.
  - disarm = 1 in any state -> DISARMED next cycle; duty1 <= 0 at that same edge, not frame-gated. disarm overrides arm_req and any ch1 command on the same cycle.
- Reset mid-operation, including mid-ramp or mid-arming, returns everything to the reset values in one cycle.

Decomposition:
- Package pwm_sched_pkg:
  - esc_state_t enum {DISARMED, ARMING, ARMED}.
  - Channel id constants CH_SERVO0 = 0, CH_ESC = 1, CH_SERVO2 = 2.
  - DUTY_W, clamp limits and step defaults.
- Sub-module pwm_ramp_channel, instantiated 3×:
  - Contains the target register, clamp, and per-frame step logic.
  - Inputs: load, load_val, frame, enable, force, force_val.
  - Outputs: duty, clamped.
- The top level holds the handshake, error generation and ESC FSM.

Test Plan:
- Reset -> duty0 = 18000, duty1 = 0, duty2 = 18000, esc_armed = 0, cmd_ready = 1 one cycle after release.
- Command ch0 = 21000, then 6 frame0 strobes -> duty0 steps 18600, 19200, 19800, 20400, 21000, 21000; no change between strobes.
- Command ch2 = 30000 -> cmd_err pulse; target2 = 24000; after 10 frame2 strobes duty2 = 24000. Command ch3 -> cmd_err pulse; no register changes.
- Arming (ARM_FRAMES = 4 in sim): ch1 = 15000 while DISARMED -> cmd_err, duty1 stays 0. Then arm_req = 1 -> duty1 = 12000; 4th frame1 -> esc_armed = 1. Then ch1 = 15000 -> duty1 12240 after the next frame1, reaching 15000 after 12 more frames.
- disarm mid-ramp while ARMED with duty1 = 13200 -> duty1 = 0 and esc_armed = 0 on the next cycle, with no frame1 needed. Asserting arm_req and disarm on the same cycle -> stays DISARMED.
- Command ch0 on the same cycle as frame0 -> duty0 steps toward the old target on that frame and the new target from the following frame. rst_n low during ARMING -> all reset values next cycle.
